// File: rtl/breakout_pkg.sv
// Shared Breakout play-field constants, paddle FSM/direction enums and the
// saturating paddle step used by the paddle controller.
package breakout_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned PADDLE_W = 80;
  localparam int unsigned X_W      = 10;
  localparam int unsigned X_MAX    = SCREEN_W - PADDLE_W;
  localparam int unsigned X_INIT   = X_MAX / 2;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } paddle_state_t;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_L,
    DIR_R
  } dir_t;

  // One paddle step toward dir, saturating at both walls; widened by a bit so
  // neither the subtract nor the add can wrap.
  function automatic logic [X_W-1:0] step_x(input logic [X_W-1:0] x,
                                            input dir_t           dir,
                                            input logic [X_W-1:0] step);
    logic [X_W:0] xe;
    logic [X_W:0] se;
    logic [X_W:0] xm;
    logic [X_W:0] r;
    xe = {1'b0, x};
    se = {1'b0, step};
    xm = (X_W+1)'(X_MAX);
    r  = xe;
    case (dir)
      DIR_L:   r = (xe < se) ? '0 : (xe - se);
      DIR_R:   r = (xe > (xm - se)) ? xm : (xe + se);
      default: r = xe;
    endcase
    return r[X_W-1:0];
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: remembers last cycle's level, flags a 0->1 change
// combinationally in the cycle the new level is seen.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise_c
);

  logic d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d;
  end

  assign rise_c = d & ~d_q;

endmodule

// File: rtl/paddle_ctrl.sv
// Breakout paddle controller: press-step, frame-paced auto-repeat, wall
// clamping, recenter and a single-cycle launch request.
module paddle_ctrl
  import breakout_pkg::*;
#(
  parameter int unsigned STEP         = 8,
  parameter int unsigned REPEAT_DELAY = 20,
  parameter int unsigned REPEAT_RATE  = 2
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           btn_left,
  input  logic           btn_right,
  input  logic           btn_launch,
  input  logic           frame_tick,
  input  logic           recenter,
  input  logic           launch_en,
  output logic [X_W-1:0] paddle_x,
  output logic           at_left,
  output logic           at_right,
  output logic           launch_pulse
);

  localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  paddle_state_t  state_q, state_d;
  dir_t           dir_q, dir_c;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_c, limit_c;
  logic [X_W-1:0] x_q, x_d;
  logic           armed_q, armed_d;
  logic           launch_pulse_q, launch_pulse_d;
  logic           step_c;
  logic           active_c;
  logic           press_c;
  logic           launch_rise_c;

  always_comb begin
    dir_c = DIR_NONE;
    case ({btn_left, btn_right})
      2'b10:   dir_c = DIR_L;
      2'b01:   dir_c = DIR_R;
      default: dir_c = DIR_NONE;
    endcase
  end

  assign active_c = (dir_c != DIR_NONE);

  rise_detect u_press_rise (
    .clk    (CLK),
    .rst_n  (RST_N),
    .d      (active_c),
    .rise_c (press_c)
  );

  rise_detect u_launch_rise (
    .clk    (CLK),
    .rst_n  (RST_N),
    .d      (btn_launch),
    .rise_c (launch_rise_c)
  );

  assign cnt_inc_c = cnt_q + CNT_W'(1);
  assign limit_c   = (state_q == HOLD) ? CNT_W'(REPEAT_DELAY) : CNT_W'(REPEAT_RATE);

  // Next state; armed_q records that the buttons have been released since the
  // last reset/recenter, so a button held across either must be re-pressed.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    x_d            = x_q;
    armed_d        = armed_q | ~active_c;
    step_c         = 1'b0;
    launch_pulse_d = launch_rise_c & launch_en;

    if (recenter) begin
      x_d     = X_W'(X_INIT);
      state_d = IDLE;
      cnt_d   = '0;
      armed_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (press_c && armed_q) begin
            step_c  = 1'b1;
            state_d = HOLD;
            cnt_d   = '0;
          end
        end
        HOLD, REPEAT: begin
          if (!active_c) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (dir_c != dir_q) begin
            step_c  = 1'b1;
            state_d = HOLD;
            cnt_d   = '0;
          end else if (frame_tick) begin
            if (cnt_inc_c == limit_c) begin
              step_c  = 1'b1;
              state_d = REPEAT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc_c;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
      if (step_c) x_d = step_x(x_q, dir_c, X_W'(STEP));
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q        <= IDLE;
      dir_q          <= DIR_NONE;
      cnt_q          <= '0;
      x_q            <= X_W'(X_INIT);
      armed_q        <= 1'b0;
      launch_pulse_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      dir_q          <= dir_c;
      cnt_q          <= cnt_d;
      x_q            <= x_d;
      armed_q        <= armed_d;
      launch_pulse_q <= launch_pulse_d;
    end
  end

  assign paddle_x     = x_q;
  assign at_left      = (x_q == '0);
  assign at_right     = (x_q == X_W'(X_MAX));
  assign launch_pulse = launch_pulse_q;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench for paddle_ctrl: hand-computed positions and pulse counts.
module tb_paddle_ctrl;

  logic       clk;
  logic       rst_n;
  logic       btn_left, btn_right, btn_launch;
  logic       frame_tick, recenter, launch_en;
  logic [9:0] paddle_x;
  logic       at_left, at_right, launch_pulse;

  int n_tests = 0;
  int n_fail  = 0;

  paddle_ctrl dut (
    .CLK          (clk),
    .RST_N        (rst_n),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_launch   (btn_launch),
    .frame_tick   (frame_tick),
    .recenter     (recenter),
    .launch_en    (launch_en),
    .paddle_x     (paddle_x),
    .at_left      (at_left),
    .at_right     (at_right),
    .launch_pulse (launch_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n clock edges, landing 1 ns after the last one.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // n frame ticks, one every 4 clocks.
  task automatic frame(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      cyc(1);
      frame_tick = 1'b0;
      cyc(3);
    end
  endtask

  int pulses;

  initial begin
    rst_n = 1'b0;
    btn_left = 1'b0; btn_right = 1'b0; btn_launch = 1'b0;
    frame_tick = 1'b0; recenter = 1'b0; launch_en = 1'b0;
    cyc(2);
    check_eq("rst_x", int'(paddle_x), 280);
    check_eq("rst_at_left", int'(at_left), 0);
    check_eq("rst_at_right", int'(at_right), 0);
    check_eq("rst_launch", int'(launch_pulse), 0);
    rst_n = 1'b1;
    cyc(3);
    check_eq("idle_x", int'(paddle_x), 280);

    // Press right: immediate step, then 20-tick delay, then every 2 ticks.
    btn_right = 1'b1;
    cyc(1);
    check_eq("press_r", int'(paddle_x), 288);
    frame(19);
    check_eq("hold_19", int'(paddle_x), 288);
    frame(1);
    check_eq("hold_20", int'(paddle_x), 296);
    frame(1);
    check_eq("rep_1", int'(paddle_x), 296);
    frame(1);
    check_eq("rep_2", int'(paddle_x), 304);

    // Asynchronous reset mid-repeat, then no motion with the button still held.
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_x", int'(paddle_x), 280);
    cyc(2);
    rst_n = 1'b1;
    frame(5);
    check_eq("rst_rearm", int'(paddle_x), 280);
    btn_right = 1'b0;
    cyc(2);

    // Both buttons: no direction.
    btn_left = 1'b1; btn_right = 1'b1;
    frame(25);
    check_eq("both_btn", int'(paddle_x), 280);
    btn_left = 1'b0; btn_right = 1'b0;
    cyc(2);

    // Left down to the wall and beyond.
    btn_left = 1'b1;
    cyc(1);
    check_eq("press_l", int'(paddle_x), 272);
    frame(20);
    check_eq("l_hold_20", int'(paddle_x), 264);
    frame(66);
    check_eq("l_wall", int'(paddle_x), 0);
    frame(10);
    check_eq("l_wall_sat", int'(paddle_x), 0);
    check_eq("at_left", int'(at_left), 1);
    check_eq("at_right_l", int'(at_right), 0);

    // Direct switch left->right, then run to the right wall.
    btn_left = 1'b0; btn_right = 1'b1;
    cyc(1);
    check_eq("switch_r", int'(paddle_x), 8);
    frame(19);
    check_eq("switch_r_19", int'(paddle_x), 8);
    frame(1);
    check_eq("switch_r_20", int'(paddle_x), 16);
    frame(140);
    check_eq("r_wall", int'(paddle_x), 560);
    check_eq("at_right", int'(at_right), 1);
    check_eq("at_left_r", int'(at_left), 0);

    // Direct switch right->left in repeat: immediate step, delay restarts.
    btn_right = 1'b0; btn_left = 1'b1;
    cyc(1);
    check_eq("switch_l", int'(paddle_x), 552);
    frame(19);
    check_eq("switch_l_19", int'(paddle_x), 552);
    frame(1);
    check_eq("switch_l_20", int'(paddle_x), 544);
    btn_left = 1'b0;
    cyc(2);

    // Press coincident with a frame tick: the tick is not counted.
    btn_left = 1'b1; frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    check_eq("press_tick", int'(paddle_x), 536);
    cyc(3);
    frame(19);
    check_eq("press_tick_19", int'(paddle_x), 536);
    frame(1);
    check_eq("press_tick_20", int'(paddle_x), 528);
    btn_left = 1'b0;
    cyc(2);

    // Launch: single pulse, none while held, none when disabled.
    launch_en = 1'b1;
    btn_launch = 1'b1;
    cyc(1);
    check_eq("launch_on", int'(launch_pulse), 1);
    pulses = 0;
    repeat (100) begin
      cyc(1);
      pulses += int'(launch_pulse);
    end
    check_eq("launch_held", pulses, 0);
    btn_launch = 1'b0;
    launch_en = 1'b0;
    cyc(2);
    btn_launch = 1'b1;
    pulses = 0;
    repeat (3) begin
      cyc(1);
      pulses += int'(launch_pulse);
    end
    check_eq("launch_dis", pulses, 0);
    launch_en = 1'b1;
    pulses = 0;
    repeat (5) begin
      cyc(1);
      pulses += int'(launch_pulse);
    end
    check_eq("launch_en_late", pulses, 0);
    btn_launch = 1'b0;
    cyc(2);

    // Recenter while held: back to 280 and frozen until re-press.
    btn_left = 1'b1;
    cyc(1);
    check_eq("pre_recenter", int'(paddle_x), 520);
    frame(5);
    recenter = 1'b1;
    cyc(1);
    recenter = 1'b0;
    check_eq("recenter_x", int'(paddle_x), 280);
    frame(25);
    check_eq("recenter_frozen", int'(paddle_x), 280);
    btn_left = 1'b0;
    cyc(2);
    btn_left = 1'b1;
    cyc(1);
    check_eq("repress", int'(paddle_x), 272);
    frame(21);
    check_eq("repress_21", int'(paddle_x), 264);
    recenter = 1'b1; frame_tick = 1'b1;
    cyc(1);
    recenter = 1'b0; frame_tick = 1'b0;
    check_eq("recenter_tick", int'(paddle_x), 280);
    btn_left = 1'b0;
    cyc(2);
    frame(5);
    check_eq("tick_no_dir", int'(paddle_x), 280);
    check_eq("final_at_left", int'(at_left), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
